// File: rtl/sdram_avs_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_avs_responder
// Purpose  : Avalon-MM responder standing in for the SDRAM interface IP.
//            On-chip backing RAM, fixed CAS latency read pipeline, and
//            waitrequest stalls for init, row activation and refresh.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_avs_responder #(
    parameter int MEM_AW       = 13,
    parameter int INIT_CYCLES  = 16,
    parameter int CAS_LAT      = 3,
    parameter int ROW_MISS_PEN = 4,
    parameter int REF_PERIOD   = 782,
    parameter int REF_CYCLES   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        avm_write,
    input  logic        avm_read,
    input  logic [23:0] avm_addr,
    input  logic [15:0] avm_wrdata,
    output logic [15:0] avs_rddata,
    output logic        avs_rddata_vld,
    output logic        avs_waitrequest
);

    localparam int c_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_READY    = 2'd1,
        ST_ACTIVATE = 2'd2,
        ST_REFRESH  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [c_CNT_W-1:0]         r_ref_cnt;
    logic                       r_ref_pend;
    logic [3:0]                 r_bank_vld;
    logic [3:0][12:0]           r_bank_row;
    logic [15:0]                r_mem [2**MEM_AW];
    logic [CAS_LAT-1:0]         r_pipe_vld;
    logic [CAS_LAT-1:0][15:0]   r_pipe_data;

    logic [1:0]                 w_bank;
    logic [12:0]                w_row;
    logic [MEM_AW-3:0]          w_off;
    logic [MEM_AW-1:0]          w_idx;
    logic                       w_ready;
    logic                       w_wr_acc;
    logic                       w_rd_acc;
    logic                       w_hit;
    logic                       w_miss_acc;

    // Address decode: bank bits are split around the row field; upper row
    // bits beyond the RAM depth simply alias.
    assign w_bank = {avm_addr[23], avm_addr[9]};
    assign w_row  = avm_addr[22:10];
    assign w_off  = (MEM_AW-2)'({avm_addr[22:10], avm_addr[8:0]});
    assign w_idx  = {w_bank, w_off};

    // Acceptance only depends on registered state; write wins over read.
    assign w_ready    = (r_state == ST_READY);
    assign w_wr_acc   = w_ready & ~avm_write;
    assign w_rd_acc   = w_ready & avm_write & ~avm_read;
    assign w_hit      = r_bank_vld[w_bank] && (r_bank_row[w_bank] == w_row);
    assign w_miss_acc = (w_wr_acc | w_rd_acc) & ~w_hit;

    assign avs_waitrequest = ~w_ready;
    assign avs_rddata      = r_pipe_data[CAS_LAT-1];
    assign avs_rddata_vld  = r_pipe_vld[CAS_LAT-1];

    // Next-state decode for the timing-cost state machine.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == c_CNT_W'(INIT_CYCLES - 1)) w_state_nxt = ST_READY;
            end
            ST_READY: begin
                if (r_ref_pend)      w_state_nxt = ST_REFRESH;
                else if (w_miss_acc) w_state_nxt = ST_ACTIVATE;
            end
            ST_ACTIVATE: begin
                if (r_cnt == c_CNT_W'(ROW_MISS_PEN - 1))
                    w_state_nxt = r_ref_pend ? ST_REFRESH : ST_READY;
            end
            ST_REFRESH: begin
                if (r_cnt == c_CNT_W'(REF_CYCLES - 1)) w_state_nxt = ST_READY;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // State register plus per-state cycle counter, restarted on every change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == ST_READY)) r_cnt <= '0;
            else                                                   r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Refresh interval counter; the pending flag drops when a refresh completes.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_INIT)) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
        end else if (r_ref_cnt == c_CNT_W'(REF_PERIOD - 1)) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b1;
        end else begin
            r_ref_cnt <= r_ref_cnt + c_CNT_W'(1);
            if ((r_state == ST_REFRESH) && (w_state_nxt == ST_READY)) r_ref_pend <= 1'b0;
        end
    end

    // Open-row table: cleared by init and refresh, loaded on every miss.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_INIT) || (r_state == ST_REFRESH)) begin
            r_bank_vld <= '0;
        end else if (w_miss_acc) begin
            r_bank_vld[w_bank] <= 1'b1;
            r_bank_row[w_bank] <= w_row;
        end
    end

    // Backing RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[w_idx] <= avm_wrdata;
    end

    // CAS latency pipeline; free-running so stalls never hold in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld  <= '0;
            r_pipe_data <= '0;
        end else begin
            for (int i = 1; i < CAS_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
            r_pipe_vld[0]  <= w_rd_acc;
            r_pipe_data[0] <= w_rd_acc ? r_mem[w_idx] : 16'h0000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_avs_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_avs_responder
// Purpose  : Directed scoreboard bench for sdram_avs_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_avs_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        avm_write = 1'b1;
    logic        avm_read = 1'b1;
    logic [23:0] avm_addr = '0;
    logic [15:0] avm_wrdata = '0;
    logic [15:0] avs_rddata;
    logic        avs_rddata_vld;
    logic        avs_waitrequest;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int r0 = 0;
    int last_acc = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    sdram_avs_responder dut (
        .clk            (clk),
        .rst            (rst),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_addr       (avm_addr),
        .avm_wrdata     (avm_wrdata),
        .avs_rddata     (avs_rddata),
        .avs_rddata_vld (avs_rddata_vld),
        .avs_waitrequest(avs_waitrequest)
    );

    // Free-running clock and cycle index
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cyc %0d, required completion", cyc);
        $fatal(1);
    end

    // Read-data monitor: pops the scoreboard on each valid pulse
    always @(negedge clk) begin
        if (avs_rddata_vld) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got data=%h at cyc %0d, required no valid", avs_rddata, cyc);
            end else begin
                e = sb.pop_front();
                if ((avs_rddata !== e.data) || (cyc != e.due)) begin
                    bad++;
                    $display("FAIL rd_data: got %h at cyc %0d, required %h at cyc %0d",
                             avs_rddata, cyc, e.data, e.due);
                end
            end
        end else if ((sb.size() > 0) && (sb[0].due <= cyc)) begin
            total++;
            bad++;
            e = sb.pop_front();
            $display("FAIL rd_missing: got no valid at cyc %0d, required %h", cyc, e.data);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Count waitrequest-high cycles after reset release until first READY cycle
    task automatic init_check(input string name);
        int highs = 0;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            highs++;
            if (highs > 100) break;
        end
        r0 = cyc;
        chk(name, highs, 16);
    endtask

    // One transfer; for reads d is the expected data. Checks stall count.
    task automatic access(input bit wr, input logic [23:0] a, input logic [15:0] d,
                          input int exp_stall, input string name);
        int stalls = 0;
        avm_write  = wr ? 1'b0 : 1'b1;
        avm_read   = wr ? 1'b1 : 1'b0;
        avm_addr   = a;
        avm_wrdata = d;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            stalls++;
            if (stalls > 50) break;
        end
        last_acc = cyc;
        if (!wr && stalls <= 50) sb.push_back('{data: d, due: cyc + 3});
        chk(name, stalls, exp_stall);
        @(posedge clk);
        #1;
        avm_write = 1'b1;
        avm_read  = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait", int'(avs_waitrequest), 1);
        chk("rst_vld", int'(avs_rddata_vld), 0);
        chk("rst_data", int'(avs_rddata), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        init_check("init_len");
        @(posedge clk);
        #1;

        // Write burst: first is a row miss, the rest hit
        for (int i = 0; i < 8; i++)
            access(1'b1, 24'(i), 16'hA000 + 16'(i), (i == 1) ? 4 : 0, "wr_burst_stall");
        for (int i = 0; i < 8; i++)
            access(1'b0, 24'(i), 16'hA000 + 16'(i), 0, "rd_burst_stall");

        // Same bank, row change in both directions
        access(1'b1, 24'h000400, 16'h5A5A, 0, "row1_wr_stall");
        access(1'b0, 24'h000000, 16'hA000, 4, "row0_back_stall");
        access(1'b0, 24'h000400, 16'h5A5A, 4, "row1_again_stall");
        access(1'b0, 24'h000400, 16'h5A5A, 4, "row1_hit_stall");
        access(1'b0, 24'h000000, 16'hA000, 0, "row0_miss_stall");

        // Bank interleave: bank 0 and bank 1 both open, then no stalls
        access(1'b1, 24'h000200, 16'hB0B0, 4, "b1_open_stall");
        access(1'b0, 24'h000000, 16'hA000, 4, "b0_hit_stall");
        access(1'b0, 24'h000200, 16'hB0B0, 0, "ilv_stall");
        access(1'b1, 24'h000201, 16'hB0B1, 0, "ilv_stall");
        access(1'b0, 24'h000201, 16'hB0B1, 0, "wr_then_rd_stall");
        access(1'b0, 24'h000000, 16'hA000, 0, "ilv_stall");
        access(1'b0, 24'h000200, 16'hB0B0, 0, "ilv_stall");

        // Row 4 aliases row 0 in the RAM but is a different SDRAM row
        access(1'b0, 24'h001000, 16'hA000, 0, "alias_stall");
        access(1'b0, 24'h000000, 16'hA000, 4, "alias_back_stall");
        access(1'b0, 24'h000000, 16'hA000, 4, "alias_hit_stall");

        // Refresh: ref_pend rises at r0+782, REFRESH occupies r0+783..r0+789
        while (cyc < r0 + 775) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++)
            access(1'b0, 24'(i), 16'hA000 + 16'(i), 0, "ref_stream_stall");
        access(1'b0, 24'h000200, 16'hB0B0, 7, "ref_stall");
        chk("ref_accept_cyc", last_acc - r0, 790);
        access(1'b0, 24'h000201, 16'hB0B1, 4, "post_ref_miss_stall");

        // Reset with two reads in flight
        access(1'b0, 24'h000000, 16'hA000, 0, "pre_rst_stall");
        access(1'b0, 24'h000001, 16'hA001, 4, "pre_rst_stall");
        access(1'b0, 24'h000002, 16'hA002, 0, "pre_rst_stall");
        access(1'b0, 24'h000003, 16'hA003, 0, "pre_rst_stall");
        rst = 1'b1;
        @(negedge clk);
        #1 sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_vld", int'(avs_rddata_vld), 0);
            chk("mid_rst_wait", int'(avs_waitrequest), 1);
            chk("mid_rst_data", int'(avs_rddata), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        init_check("reinit_len");
        @(posedge clk);
        #1;
        access(1'b0, 24'h000003, 16'hA003, 0, "after_rst_stall");
        access(1'b0, 24'h000201, 16'hB0B1, 4, "after_rst_stall");

        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
